// File: rtl/centroid_crosshair.sv
// centroid_crosshair
//   Closes the loop on the per-pixel threshold mask. During a frame it counts
//   mask pixels and sums their X/Y coordinates. At frame close it divides the
//   sums by the count with a sequential restoring divider. X and Y are divided
//   in parallel, one quotient bit per cycle. The resulting centroid drives a
//   registered crosshair strobe for the video mux.
//
// Ports
//   clk_in             pixel clock
//   rst_n_in           async active-low reset (asserts at once, releases on a clock edge)
//   hcount_in          current pixel X
//   vcount_in          current pixel Y
//   data_valid_in      pixel strobe; hcount/vcount/mask are valid this cycle
//   mask_in            thresholded pixel (1 = object)
//   new_frame_in       1-cycle pulse that closes the current frame
//   x_out, y_out       latest centroid
//   centroid_valid_out 1-cycle pulse when x_out/y_out update
//   busy_out           divider running (DIVIDE or DONE)
//   overrun_out        1-cycle pulse: frame dropped because the divider was busy
//   crosshair_out      registered strobe for pixels on the centroid row or column
module centroid_crosshair #(
   parameter int H_WIDTH    = 11,
   parameter int V_WIDTH    = 10,
   parameter int COUNT_W    = 20,
   parameter int MIN_PIXELS = 16
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   input  logic [H_WIDTH-1:0] hcount_in,
   input  logic [V_WIDTH-1:0] vcount_in,
   input  logic               data_valid_in,
   input  logic               mask_in,
   input  logic               new_frame_in,
   output logic [H_WIDTH-1:0] x_out,
   output logic [V_WIDTH-1:0] y_out,
   output logic               centroid_valid_out,
   output logic               busy_out,
   output logic               overrun_out,
   output logic               crosshair_out
);

   localparam int S  = H_WIDTH + COUNT_W;
   localparam int IW = $clog2(S);
   localparam logic [COUNT_W-1:0] MIN_CNT  = COUNT_W'(MIN_PIXELS);
   localparam logic [IW-1:0]      LAST_IT  = IW'(S - 1);

   typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

   // Reset synchronizer: assertion reaches every flop immediately; release is
   // aligned to the clock so no flop sees a runt recovery edge.
   logic [1:0] rst_sync;
   logic       rst_n;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) rst_sync <= '0;
      else           rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   // ---------------- accumulation ----------------
   logic               pix_hit;
   logic [COUNT_W-1:0] count, cnt_inc;
   logic [S-1:0]       sum_x, sum_y, sx_inc, sy_inc;

   assign pix_hit = data_valid_in & mask_in;

   // The *_inc values include this cycle's pixel. They double as the frame
   // snapshot, so a mask pixel coincident with new_frame_in stays with the
   // closing frame.
   always_comb begin
      cnt_inc = count;
      sx_inc  = sum_x;
      sy_inc  = sum_y;
      if (pix_hit) begin
         if (count != '1) cnt_inc = count + 1'b1;
         sx_inc = sum_x + S'(hcount_in);
         sy_inc = sum_y + S'(vcount_in);
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         sum_x <= '0;
         sum_y <= '0;
      end else if (new_frame_in) begin
         count <= '0;
         sum_x <= '0;
         sum_y <= '0;
      end else begin
         count <= cnt_inc;
         sum_x <= sx_inc;
         sum_y <= sy_inc;
      end
   end

   // ---------------- control FSM ----------------
   state_t        state, state_nxt;
   logic [IW-1:0] iter;
   logic          start, last_iter;

   assign last_iter = (iter == LAST_IT);

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      case (state)
         IDLE: begin
            if (new_frame_in && (cnt_inc >= MIN_CNT)) begin
               start     = 1'b1;
               state_nxt = DIVIDE;
            end
         end
         DIVIDE:  if (last_iter) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy_out = (state != IDLE);

   // ---------------- restoring divider ----------------
   // The quotient registers start out holding the dividend. Each step shifts
   // the dividend MSB into the partial remainder and shifts one quotient bit
   // in at the bottom. The remainder stays below the divisor, so COUNT_W bits
   // are enough to hold it. One extra bit is needed for the trial value.
   logic [COUNT_W-1:0] divisor, rem_x, rem_y, rem_x_nxt, rem_y_nxt;
   logic [S-1:0]       quo_x, quo_y, quo_x_nxt, quo_y_nxt;
   logic [COUNT_W:0]   trial_x, trial_y, diff_x, diff_y;
   logic               ge_x, ge_y;

   always_comb begin
      trial_x   = {rem_x, quo_x[S-1]};
      trial_y   = {rem_y, quo_y[S-1]};
      diff_x    = trial_x - {1'b0, divisor};
      diff_y    = trial_y - {1'b0, divisor};
      ge_x      = (trial_x >= {1'b0, divisor});
      ge_y      = (trial_y >= {1'b0, divisor});
      rem_x_nxt = ge_x ? diff_x[COUNT_W-1:0] : trial_x[COUNT_W-1:0];
      rem_y_nxt = ge_y ? diff_y[COUNT_W-1:0] : trial_y[COUNT_W-1:0];
      quo_x_nxt = {quo_x[S-2:0], ge_x};
      quo_y_nxt = {quo_y[S-2:0], ge_y};
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         divisor <= '0;
         rem_x   <= '0;
         rem_y   <= '0;
         quo_x   <= '0;
         quo_y   <= '0;
         iter    <= '0;
      end else if (start) begin
         divisor <= cnt_inc;
         rem_x   <= '0;
         rem_y   <= '0;
         quo_x   <= sx_inc;
         quo_y   <= sy_inc;
         iter    <= '0;
      end else if (state == DIVIDE) begin
         rem_x <= rem_x_nxt;
         rem_y <= rem_y_nxt;
         quo_x <= quo_x_nxt;
         quo_y <= quo_y_nxt;
         iter  <= iter + 1'b1;
      end
   end

   // ---------------- outputs ----------------
   // The result is captured from the final iteration's next-quotient. The
   // pulse and the new centroid therefore appear together in the DONE cycle.
   logic have_centroid;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         x_out              <= '0;
         y_out              <= '0;
         centroid_valid_out <= 1'b0;
         overrun_out        <= 1'b0;
         crosshair_out      <= 1'b0;
         have_centroid      <= 1'b0;
      end else begin
         centroid_valid_out <= 1'b0;
         if (state == DIVIDE && last_iter) begin
            x_out              <= quo_x_nxt[H_WIDTH-1:0];
            y_out              <= quo_y_nxt[V_WIDTH-1:0];
            centroid_valid_out <= 1'b1;
            have_centroid      <= 1'b1;
         end
         overrun_out   <= new_frame_in & busy_out;
         crosshair_out <= have_centroid & data_valid_in &
                          ((hcount_in == x_out) | (vcount_in == y_out));
      end
   end

endmodule
